// File: rtl/dcache_miss_ctrl_if.sv
// Bundle of the CPU, cache-SRAM and data-memory signals seen by dcache_miss_ctrl.
// The controller is the initiator towards the SRAM and memory, so it takes the
// master modport; the slave modport is the CPU/SRAM/memory environment.
interface dcache_miss_ctrl_if;
  // CPU memory stage
  logic         cpu_req_i;
  logic         cpu_we_i;
  logic [31:0]  cpu_addr_i;
  logic [31:0]  cpu_data_i;
  logic [31:0]  cpu_data_o;
  logic         cpu_stall_o;
  // Cache SRAM port
  logic [3:0]   sram_addr_o;
  logic [24:0]  sram_tag_o;
  logic [255:0] sram_data_o;
  logic         sram_enable_o;
  logic         sram_write_o;
  logic [24:0]  sram_tag_i;
  logic [255:0] sram_data_i;
  logic         sram_hit_i;
  // Data memory handshake
  logic         mem_enable_o;
  logic         mem_write_o;
  logic [31:0]  mem_addr_o;
  logic [255:0] mem_data_o;
  logic [255:0] mem_data_i;
  logic         mem_ack_i;

  modport master (
    input  cpu_req_i, cpu_we_i, cpu_addr_i, cpu_data_i,
    output cpu_data_o, cpu_stall_o,
    output sram_addr_o, sram_tag_o, sram_data_o, sram_enable_o, sram_write_o,
    input  sram_tag_i, sram_data_i, sram_hit_i,
    output mem_enable_o, mem_write_o, mem_addr_o, mem_data_o,
    input  mem_data_i, mem_ack_i
  );

  modport slave (
    output cpu_req_i, cpu_we_i, cpu_addr_i, cpu_data_i,
    input  cpu_data_o, cpu_stall_o,
    input  sram_addr_o, sram_tag_o, sram_data_o, sram_enable_o, sram_write_o,
    output sram_tag_i, sram_data_i, sram_hit_i,
    input  mem_enable_o, mem_write_o, mem_addr_o, mem_data_o,
    output mem_data_i, mem_ack_i
  );
endinterface

// File: rtl/dcache_miss_ctrl.sv
// Data-cache miss controller: probes the 2-way SRAM for CPU loads/stores, merges
// store words on hits, and on a miss writes back a dirty victim then refills the
// line from the 256-bit memory. Geometry: 16 sets, 256-bit lines, 23-bit tag.
// Optional event counters are built when DCACHE_PERF_CNT_EN is defined.
module dcache_miss_ctrl (
  input  logic                clk_i,
  input  logic                rst_i,  // synchronous, active low
  dcache_miss_ctrl_if.master  bus,
  output logic [31:0]         perf_hit_o,
  output logic [31:0]         perf_miss_o,
  output logic [31:0]         perf_wb_o
);

  typedef enum logic [2:0] {StIdle, StMiss, StWback, StRefill, StUpdate} state_e;

  state_e        state_q, state_d;
  logic [24:0]   victim_tag_q, victim_tag_d;
  // Holds the victim line until writeback, then the refill line until UPDATE.
  logic [255:0]  line_q, line_d;
  logic [22:0]   req_tag_q, req_tag_d;
  logic [3:0]    req_idx_q, req_idx_d;

  logic [7:0]    word_lsb;
  logic [255:0]  merged_line;
  logic          hit_ev, miss_ev, wb_ev;

  assign word_lsb = {bus.cpu_addr_i[4:2], 5'b0};

  // Hit line with the addressed word replaced by the store data.
  always_comb begin
    merged_line = bus.sram_data_i;
    merged_line[word_lsb +: 32] = bus.cpu_data_i;
  end

  // Next-state, latch updates and all bus outputs.
  always_comb begin
    state_d      = state_q;
    victim_tag_d = victim_tag_q;
    line_d       = line_q;
    req_tag_d    = req_tag_q;
    req_idx_d    = req_idx_q;
    hit_ev       = 1'b0;
    miss_ev      = 1'b0;
    wb_ev        = 1'b0;

    bus.cpu_data_o    = 32'h0;
    bus.cpu_stall_o   = 1'b0;
    bus.sram_addr_o   = 4'h0;
    bus.sram_tag_o    = 25'h0;
    bus.sram_data_o   = 256'h0;
    bus.sram_enable_o = 1'b0;
    bus.sram_write_o  = 1'b0;
    bus.mem_enable_o  = 1'b0;
    bus.mem_write_o   = 1'b0;
    bus.mem_addr_o    = 32'h0;
    bus.mem_data_o    = 256'h0;

    unique case (state_q)
      StIdle: begin
        bus.sram_enable_o = bus.cpu_req_i;
        if (bus.cpu_req_i) begin
          bus.sram_addr_o = bus.cpu_addr_i[8:5];
          bus.sram_tag_o  = {1'b1, bus.cpu_we_i, bus.cpu_addr_i[31:9]};
          if (bus.sram_hit_i) begin
            hit_ev = 1'b1;
            if (bus.cpu_we_i) begin
              bus.sram_write_o = 1'b1;
              bus.sram_data_o  = merged_line;
            end else begin
              bus.cpu_data_o = bus.sram_data_i[word_lsb +: 32];
            end
          end else begin
            // sram_tag_i/sram_data_i carry the replacement candidate on a miss.
            bus.cpu_stall_o = 1'b1;
            miss_ev         = 1'b1;
            victim_tag_d    = bus.sram_tag_i;
            line_d          = bus.sram_data_i;
            req_tag_d       = bus.cpu_addr_i[31:9];
            req_idx_d       = bus.cpu_addr_i[8:5];
            state_d         = StMiss;
          end
        end
      end

      StMiss: begin
        bus.cpu_stall_o = 1'b1;
        state_d = (victim_tag_q[24] && victim_tag_q[23]) ? StWback : StRefill;
      end

      StWback: begin
        bus.cpu_stall_o  = 1'b1;
        bus.mem_enable_o = 1'b1;
        bus.mem_write_o  = 1'b1;
        bus.mem_addr_o   = {victim_tag_q[22:0], req_idx_q, 5'b0};
        bus.mem_data_o   = line_q;
        if (bus.mem_ack_i) begin
          wb_ev   = 1'b1;
          state_d = StRefill;
        end
      end

      StRefill: begin
        bus.cpu_stall_o  = 1'b1;
        bus.mem_enable_o = 1'b1;
        bus.mem_addr_o   = {req_tag_q, req_idx_q, 5'b0};
        if (bus.mem_ack_i) begin
          line_d  = bus.mem_data_i;
          state_d = StUpdate;
        end
      end

      StUpdate: begin
        // Install the clean line; the held request re-probes and hits next cycle.
        bus.cpu_stall_o   = 1'b1;
        bus.sram_enable_o = 1'b1;
        bus.sram_write_o  = 1'b1;
        bus.sram_addr_o   = req_idx_q;
        bus.sram_tag_o    = {2'b10, req_tag_q};
        bus.sram_data_o   = line_q;
        state_d           = StIdle;
      end

      default: state_d = StIdle;
    endcase
  end

  // State and latched-request registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q      <= StIdle;
      victim_tag_q <= 25'h0;
      line_q       <= 256'h0;
      req_tag_q    <= 23'h0;
      req_idx_q    <= 4'h0;
    end else begin
      state_q      <= state_d;
      victim_tag_q <= victim_tag_d;
      line_q       <= line_d;
      req_tag_q    <= req_tag_d;
      req_idx_q    <= req_idx_d;
    end
  end

`ifdef DCACHE_PERF_CNT_EN
  logic [31:0] perf_hit_q, perf_hit_d;
  logic [31:0] perf_miss_q, perf_miss_d;
  logic [31:0] perf_wb_q, perf_wb_d;

  // Event counters; wrap from all-ones to zero.
  always_comb begin
    perf_hit_d  = perf_hit_q + {31'b0, hit_ev};
    perf_miss_d = perf_miss_q + {31'b0, miss_ev};
    perf_wb_d   = perf_wb_q + {31'b0, wb_ev};
  end

  // Counter registers, cleared by reset.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      perf_hit_q  <= 32'h0;
      perf_miss_q <= 32'h0;
      perf_wb_q   <= 32'h0;
    end else begin
      perf_hit_q  <= perf_hit_d;
      perf_miss_q <= perf_miss_d;
      perf_wb_q   <= perf_wb_d;
    end
  end

  assign perf_hit_o  = perf_hit_q;
  assign perf_miss_o = perf_miss_q;
  assign perf_wb_o   = perf_wb_q;
`else
  logic unused_ev;
  assign unused_ev   = hit_ev ^ miss_ev ^ wb_ev;
  assign perf_hit_o  = 32'h0;
  assign perf_miss_o = 32'h0;
  assign perf_wb_o   = 32'h0;
`endif

endmodule

// File: tb/tb_dcache_miss_ctrl.sv
// Bench for dcache_miss_ctrl: a one-way-per-set SRAM model, a memory responder
// with fixed latency, and scoreboards of expected load data and memory transfers.
module tb_dcache_miss_ctrl;

  typedef struct {
    logic [31:0]  addr;
    logic         wr;
    logic [255:0] data;
  } txn_t;

  logic        clk = 1'b0;
  logic        rst_i;
  logic [31:0] perf_hit, perf_miss, perf_wb;

  always #5 clk = ~clk;

  dcache_miss_ctrl_if bus ();

  dcache_miss_ctrl dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .bus         (bus),
    .perf_hit_o  (perf_hit),
    .perf_miss_o (perf_miss),
    .perf_wb_o   (perf_wb)
  );

  int n_chk  = 0;
  int n_fail = 0;

  txn_t        exp_q[$];
  txn_t        obs_q[$];
  logic [31:0] exp_rd_q[$];

  function automatic logic [255:0] line_pat(input logic [31:0] a);
    logic [255:0] l;
    for (int k = 0; k < 8; k++) l[k*32 +: 32] = a ^ (32'h1111_1111 * (k + 1));
    return l;
  endfunction

  // SRAM model: one resident line per set, written by preload or by the DUT.
  logic [24:0]  m_tag  [16];
  logic [255:0] m_line [16];
  logic         pl_en = 1'b0;
  logic [3:0]   pl_idx;
  logic [24:0]  pl_tag;
  logic [255:0] pl_line;

  always @(posedge clk) begin
    if (pl_en) begin
      m_tag[pl_idx]  <= pl_tag;
      m_line[pl_idx] <= pl_line;
    end else if (bus.sram_enable_o && bus.sram_write_o) begin
      m_tag[bus.sram_addr_o]  <= bus.sram_tag_o;
      m_line[bus.sram_addr_o] <= bus.sram_data_o;
    end
  end

  assign bus.sram_tag_i  = m_tag[bus.cpu_addr_i[8:5]];
  assign bus.sram_data_i = m_line[bus.cpu_addr_i[8:5]];
  assign bus.sram_hit_i  = m_tag[bus.cpu_addr_i[8:5]][24] &&
                           (m_tag[bus.cpu_addr_i[8:5]][22:0] == bus.cpu_addr_i[31:9]);

  // Memory responder: ack lands in the mem_lat-th cycle of a request.
  int unsigned mem_lat = 4;
  int unsigned ack_cnt = 0;
  logic        auto_en = 1'b1;
  logic        auto_ack = 1'b0;
  logic        man_ack = 1'b0;

  assign bus.mem_ack_i  = auto_ack | man_ack;
  assign bus.mem_data_i = line_pat(bus.mem_addr_o);

  always @(posedge clk) begin
    if (auto_ack) begin
      auto_ack <= 1'b0;
      ack_cnt  <= 0;
    end else if (auto_en && bus.mem_enable_o) begin
      if (ack_cnt + 1 == mem_lat - 1) auto_ack <= 1'b1;
      ack_cnt <= ack_cnt + 1;
    end else begin
      ack_cnt <= 0;
    end
  end

  // Record every completed memory transfer.
  always @(negedge clk) begin
    if (rst_i && bus.mem_enable_o && bus.mem_ack_i)
      obs_q.push_back('{bus.mem_addr_o, bus.mem_write_o, bus.mem_data_o});
  end

  task automatic preload(input logic [3:0] idx, input logic [24:0] tag, input logic [255:0] line);
    @(posedge clk); #1;
    pl_en = 1'b1; pl_idx = idx; pl_tag = tag; pl_line = line;
    @(posedge clk); #1;
    pl_en = 1'b0;
  endtask

  // Drive one request and hold it until the stall drops; report what was seen.
  task automatic cpu_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                            output int stalls, output logic [31:0] rdata, output logic s_wr,
                            output logic [24:0] s_tag, output logic [255:0] s_data,
                            output logic timed_out);
    stalls = 0; rdata = '0; s_wr = 1'b0; s_tag = '0; s_data = '0; timed_out = 1'b1;
    @(posedge clk); #1;
    bus.cpu_req_i = 1'b1; bus.cpu_we_i = we; bus.cpu_addr_i = addr; bus.cpu_data_i = wdata;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (!bus.cpu_stall_o) begin
        rdata = bus.cpu_data_o; s_wr = bus.sram_write_o;
        s_tag = bus.sram_tag_o; s_data = bus.sram_data_o;
        timed_out = 1'b0;
        break;
      end
      stalls++;
    end
    @(posedge clk); #1;
    bus.cpu_req_i = 1'b0;
  endtask

  logic [255:0] line2;

  task automatic test_reset();
    rst_i = 1'b0;
    bus.cpu_req_i = 1'b0; bus.cpu_we_i = 1'b0; bus.cpu_addr_i = '0; bus.cpu_data_i = '0;
    for (int i = 0; i < 16; i++) preload(i[3:0], 25'h0, 256'h0);
    @(negedge clk);
    n_chk++; if (bus.cpu_stall_o !== 1'b0) begin n_fail++; $display("FAIL reset_stall got %b want 0", bus.cpu_stall_o); end
    n_chk++; if (bus.mem_enable_o !== 1'b0) begin n_fail++; $display("FAIL reset_mem_en got %b want 0", bus.mem_enable_o); end
    n_chk++; if (bus.sram_enable_o !== 1'b0) begin n_fail++; $display("FAIL reset_sram_en got %b want 0", bus.sram_enable_o); end
    n_chk++; if ({perf_hit, perf_miss, perf_wb} !== 96'h0) begin n_fail++; $display("FAIL reset_perf got %0d/%0d/%0d want 0/0/0", perf_hit, perf_miss, perf_wb); end
    @(posedge clk); #1;
    rst_i = 1'b1;
  endtask

  task automatic test_load_hit();
    int st; logic [31:0] rd; logic wr; logic [24:0] tg; logic [255:0] dt; logic to;
    line2 = line_pat(32'hABCD_0000);
    line2[3*32 +: 32] = 32'hDEAD_BEEF;
    preload(4'd2, {2'b10, 23'h0}, line2);
    exp_rd_q.push_back(32'hDEAD_BEEF);
    cpu_access(1'b0, 32'h0000_004C, 32'h0, st, rd, wr, tg, dt, to);
    n_chk++; if (to !== 1'b0 || st != 0) begin n_fail++; $display("FAIL load_hit_stall got %0d cycles (timeout %b) want 0", st, to); end
    n_chk++; if (rd !== exp_rd_q.pop_front()) begin n_fail++; $display("FAIL load_hit_data got %h want deadbeef", rd); end
    n_chk++; if (wr !== 1'b0) begin n_fail++; $display("FAIL load_hit_sram_write got %b want 0", wr); end
    n_chk++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL load_hit_no_mem got %0d transfers want 0", obs_q.size()); obs_q.delete(); end
  endtask

  task automatic test_store_hit();
    int st; logic [31:0] rd; logic wr; logic [24:0] tg; logic [255:0] dt; logic to;
    logic [255:0] exp_line;
    exp_line = line2;
    exp_line[2*32 +: 32] = 32'h1234_5678;
    cpu_access(1'b1, 32'h0000_0048, 32'h1234_5678, st, rd, wr, tg, dt, to);
    n_chk++; if (to !== 1'b0 || st != 0) begin n_fail++; $display("FAIL store_hit_stall got %0d cycles want 0", st); end
    n_chk++; if (wr !== 1'b1) begin n_fail++; $display("FAIL store_hit_sram_write got %b want 1", wr); end
    n_chk++; if (tg !== {2'b11, 23'h0}) begin n_fail++; $display("FAIL store_hit_tag got %h want %h", tg, {2'b11, 23'h0}); end
    n_chk++; if (dt !== exp_line) begin n_fail++; $display("FAIL store_hit_line got %h want %h", dt, exp_line); end
  endtask

  task automatic test_clean_miss();
    int st; logic [31:0] rd; logic wr; logic [24:0] tg; logic [255:0] dt; logic to;
    logic [255:0] rl; txn_t e; txn_t o;
    preload(4'd2, 25'h0, 256'h0);
    rl = line_pat(32'h0000_0040);
    exp_q.push_back('{32'h0000_0040, 1'b0, 256'h0});
    exp_rd_q.push_back(rl[31:0]);
    cpu_access(1'b0, 32'h0000_0040, 32'h0, st, rd, wr, tg, dt, to);
    // Stalled cycles: the missing request cycle, MISS, REFILL x L, UPDATE.
    n_chk++; if (to !== 1'b0 || st != 1 + 1 + int'(mem_lat) + 1) begin n_fail++; $display("FAIL clean_miss_stall got %0d want %0d", st, 3 + mem_lat); end
    n_chk++; if (rd !== exp_rd_q.pop_front()) begin n_fail++; $display("FAIL clean_miss_data got %h want %h", rd, rl[31:0]); end
    n_chk++; if (m_tag[2] !== {2'b10, 23'h0}) begin n_fail++; $display("FAIL clean_miss_update_tag got %h want %h", m_tag[2], {2'b10, 23'h0}); end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      n_chk++;
      if (obs_q.size() == 0) begin n_fail++; $display("FAIL clean_miss_mem got none want addr %h wr %b", e.addr, e.wr); end
      else begin
        o = obs_q.pop_front();
        if (o.addr !== e.addr || o.wr !== e.wr) begin n_fail++; $display("FAIL clean_miss_mem got addr %h wr %b want addr %h wr %b", o.addr, o.wr, e.addr, e.wr); end
      end
    end
    n_chk++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL clean_miss_extra_mem got %0d want 0", obs_q.size()); obs_q.delete(); end
  endtask

  task automatic test_dirty_miss();
    int st; logic [31:0] rd; logic wr; logic [24:0] tg; logic [255:0] dt; logic to;
    logic [255:0] vline; logic [255:0] exp_line; txn_t e; txn_t o;
    vline = line_pat(32'h0BAD_0000);
    preload(4'd2, {2'b11, 23'h1}, vline);
    exp_q.push_back('{32'h0000_0240, 1'b1, vline});
    exp_q.push_back('{32'h0000_0040, 1'b0, 256'h0});
    exp_line = line_pat(32'h0000_0040);
    exp_line[1*32 +: 32] = 32'hCAFE_F00D;
    cpu_access(1'b1, 32'h0000_0044, 32'hCAFE_F00D, st, rd, wr, tg, dt, to);
    // Stalled cycles: request cycle, MISS, WBACK x L', REFILL x L, UPDATE.
    n_chk++; if (to !== 1'b0 || st != 3 + 2 * int'(mem_lat)) begin n_fail++; $display("FAIL dirty_miss_stall got %0d want %0d", st, 3 + 2 * mem_lat); end
    n_chk++; if (wr !== 1'b1 || tg !== {2'b11, 23'h0}) begin n_fail++; $display("FAIL dirty_miss_store got wr %b tag %h want wr 1 tag %h", wr, tg, {2'b11, 23'h0}); end
    n_chk++; if (dt !== exp_line) begin n_fail++; $display("FAIL dirty_miss_line got %h want %h", dt, exp_line); end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      n_chk++;
      if (obs_q.size() == 0) begin n_fail++; $display("FAIL dirty_miss_mem got none want addr %h wr %b", e.addr, e.wr); end
      else begin
        o = obs_q.pop_front();
        if (o.addr !== e.addr || o.wr !== e.wr || (e.wr && o.data !== e.data)) begin
          n_fail++; $display("FAIL dirty_miss_mem got addr %h wr %b data %h want addr %h wr %b data %h", o.addr, o.wr, o.data, e.addr, e.wr, e.data);
        end
      end
    end
    n_chk++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL dirty_miss_extra_mem got %0d want 0", obs_q.size()); obs_q.delete(); end
  endtask

  task automatic test_back_to_back();
    logic [255:0] la; logic [255:0] lb;
    la = line_pat(32'h0000_06E0);
    lb = line_pat(32'h0000_0B00);
    preload(4'd7, {2'b10, 23'h3}, la);
    preload(4'd8, {2'b10, 23'h5}, lb);
    exp_rd_q.push_back(la[5*32 +: 32]);
    exp_rd_q.push_back(lb[6*32 +: 32]);
    @(posedge clk); #1;
    bus.cpu_req_i = 1'b1; bus.cpu_we_i = 1'b0; bus.cpu_addr_i = 32'h0000_06F4;
    @(negedge clk);
    n_chk++; if (bus.cpu_stall_o !== 1'b0 || bus.cpu_data_o !== exp_rd_q.pop_front()) begin n_fail++; $display("FAIL b2b_first got stall %b data %h want 0 %h", bus.cpu_stall_o, bus.cpu_data_o, la[5*32 +: 32]); end
    @(posedge clk); #1;
    bus.cpu_addr_i = 32'h0000_0B18;
    @(negedge clk);
    n_chk++; if (bus.cpu_stall_o !== 1'b0 || bus.cpu_data_o !== exp_rd_q.pop_front()) begin n_fail++; $display("FAIL b2b_second got stall %b data %h want 0 %h", bus.cpu_stall_o, bus.cpu_data_o, lb[6*32 +: 32]); end
    @(posedge clk); #1;
    bus.cpu_we_i = 1'b1; bus.cpu_addr_i = 32'h0000_06F4; bus.cpu_data_i = 32'h5555_AAAA;
    @(negedge clk);
    n_chk++; if (bus.cpu_stall_o !== 1'b0 || bus.sram_write_o !== 1'b1 || bus.sram_addr_o !== 4'd7) begin n_fail++; $display("FAIL b2b_store got stall %b write %b idx %0d want 0 1 7", bus.cpu_stall_o, bus.sram_write_o, bus.sram_addr_o); end
    @(posedge clk); #1;
    bus.cpu_req_i = 1'b0; bus.cpu_we_i = 1'b0;
  endtask

  task automatic test_reset_refill();
    logic seen;
    preload(4'd5, 25'h0, 256'h0);
    auto_en = 1'b0;
    seen = 1'b0;
    @(posedge clk); #1;
    bus.cpu_req_i = 1'b1; bus.cpu_we_i = 1'b0; bus.cpu_addr_i = 32'h0000_00A0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (bus.mem_enable_o) begin seen = 1'b1; break; end
    end
    n_chk++; if (seen !== 1'b1 || bus.mem_write_o !== 1'b0 || bus.mem_addr_o !== 32'h0000_00A0) begin n_fail++; $display("FAIL rst_refill_start got en %b addr %h want 1 000000a0", seen, bus.mem_addr_o); end
    @(posedge clk); #1;
    rst_i = 1'b0; bus.cpu_req_i = 1'b0;
    @(posedge clk); #1;
    rst_i = 1'b1;
    @(negedge clk);
    n_chk++; if (bus.mem_enable_o !== 1'b0 || bus.cpu_stall_o !== 1'b0) begin n_fail++; $display("FAIL rst_refill_abort got en %b stall %b want 0 0", bus.mem_enable_o, bus.cpu_stall_o); end
    n_chk++; if ({perf_hit, perf_miss, perf_wb} !== 96'h0) begin n_fail++; $display("FAIL rst_refill_perf got %0d/%0d/%0d want 0/0/0", perf_hit, perf_miss, perf_wb); end
    @(posedge clk); #1;
    man_ack = 1'b1;
    @(posedge clk); #1;
    man_ack = 1'b0;
    @(negedge clk);
    n_chk++; if (bus.mem_enable_o !== 1'b0 || bus.cpu_stall_o !== 1'b0 || bus.sram_write_o !== 1'b0) begin n_fail++; $display("FAIL rst_late_ack got en %b stall %b wr %b want 0 0 0", bus.mem_enable_o, bus.cpu_stall_o, bus.sram_write_o); end
    n_chk++; if (m_tag[5] !== 25'h0 || obs_q.size() != 0) begin n_fail++; $display("FAIL rst_late_ack_state got tag %h transfers %0d want 0 0", m_tag[5], obs_q.size()); obs_q.delete(); end
    auto_en = 1'b1;
  endtask

  task automatic test_perf();
    int st; logic [31:0] rd; logic wr; logic [24:0] tg; logic [255:0] dt; logic to;
    logic [31:0] eh, em, ew;
    preload(4'd9, {2'b10, 23'h0}, line_pat(32'h0000_0120));
    preload(4'd10, 25'h0, 256'h0);
    preload(4'd11, {2'b11, 23'h2}, line_pat(32'h0000_0560));
    cpu_access(1'b0, 32'h0000_0124, 32'h0, st, rd, wr, tg, dt, to);
    cpu_access(1'b0, 32'h0000_0140, 32'h0, st, rd, wr, tg, dt, to);
    cpu_access(1'b1, 32'h0000_0168, 32'h7777_0000, st, rd, wr, tg, dt, to);
    obs_q.delete();
`ifdef DCACHE_PERF_CNT_EN
    // One direct hit plus the re-probe hit that closes each of the two misses.
    eh = 32'd3; em = 32'd2; ew = 32'd1;
`else
    eh = 32'd0; em = 32'd0; ew = 32'd0;
`endif
    n_chk++; if (perf_hit !== eh) begin n_fail++; $display("FAIL perf_hit got %0d want %0d", perf_hit, eh); end
    n_chk++; if (perf_miss !== em) begin n_fail++; $display("FAIL perf_miss got %0d want %0d", perf_miss, em); end
    n_chk++; if (perf_wb !== ew) begin n_fail++; $display("FAIL perf_wb got %0d want %0d", perf_wb, ew); end
  endtask

  initial begin
    test_reset();
    test_load_hit();
    test_store_hit();
    test_clean_miss();
    test_dirty_miss();
    test_back_to_back();
    test_reset_refill();
    test_perf();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
